// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle ARM-subset control path:
// FSM states, ALU/extender/mux select codes and condition codes.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_unit.sv
// Condition-code evaluation against the NZCV register,
// and the NZCV register itself with its S-bit update rule.
import cpu_pkg::*;

module cond_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_write,
    input  logic       arith,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c && !z;
            COND_LS: cond_ex = !c || z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z && (n == v);
            COND_LE: cond_ex = z || (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
        endcase
    end

    // Logical ops leave carry and overflow untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (flag_write) begin
            flags[3:2] <= alu_flags[3:2];
            if (arith)
                flags[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: decodes the IR and sequences fetch,
// decode, execute and writeback, driving all datapath selects.
import cpu_pkg::*;

module multicycle_controller #(
    parameter logic [3:0] PC_REG = 4'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic [1:0]  result_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_control,
    output logic [1:0]  imm_src,
    output logic [3:0]  flags
);

    state_t     state, next_state;
    logic [1:0] op;
    logic [3:0] cmd, rd;
    logic       i_bit, s_bit;
    logic [1:0] dp_op, alu_op_q;
    logic       legal, is_cmp, cond_ex, rd_pc;
    logic       mem_req_c, ir_c, pc_c, rw_c, mw_c;

    assign op    = instr[27:26];
    assign i_bit = instr[25];
    assign cmd   = instr[24:21];
    assign s_bit = instr[20];
    assign rd    = instr[15:12];
    assign rd_pc = (rd == PC_REG);

    assign imm_src = (op == 2'b11) ? IMM_DP : op;

    always_comb begin
        dp_op  = ALU_ADD;
        legal  = 1'b1;
        is_cmp = 1'b0;
        case (cmd)
            CMD_ADD: dp_op = ALU_ADD;
            CMD_SUB: dp_op = ALU_SUB;
            CMD_AND: dp_op = ALU_AND;
            CMD_ORR: dp_op = ALU_ORR;
            CMD_CMP: begin
                dp_op  = ALU_SUB;
                is_cmp = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    cond_unit u_cond (
        .clk        (clk),
        .rst_n      (rst_n),
        .cond       (instr[31:28]),
        .alu_flags  (alu_flags),
        .flag_write (state == S_ALUWB && s_bit),
        .arith      (alu_op_q == ALU_ADD || alu_op_q == ALU_SUB),
        .cond_ex    (cond_ex),
        .flags      (flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            alu_op_q <= ALU_ADD;
        end else begin
            state <= next_state;
            if (state == S_EXECR || state == S_EXECI)
                alu_op_q <= dp_op;
        end
    end

    always_comb begin
        next_state  = state;
        mem_req_c   = 1'b0;
        ir_c        = 1'b0;
        pc_c        = 1'b0;
        rw_c        = 1'b0;
        mw_c        = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        result_src  = RES_ALU;
        unique case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_c       = 1'b1;
                    pc_c       = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!cond_ex || op == 2'b11 || (op == OP_DP && !legal))
                    next_state = S_FETCH;
                else if (op == OP_DP)
                    next_state = i_bit ? S_EXECI : S_EXECR;
                else if (op == OP_MEM)
                    next_state = S_MEMADR;
                else
                    next_state = S_BRANCH;
            end
            S_MEMADR: begin
                alu_src_a  = 1'b0;
                alu_src_b  = SRCB_IMM;
                next_state = s_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready)
                    next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                rw_c       = 1'b1;
                pc_c       = rd_pc;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_c = 1'b1;
                mw_c      = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready)
                    next_state = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a   = 1'b0;
                alu_src_b   = (state == S_EXECI) ? SRCB_IMM : SRCB_REG;
                alu_control = dp_op;
                next_state  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                rw_c       = !is_cmp;
                pc_c       = rd_pc && !is_cmp;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b0;
                alu_src_b  = SRCB_IMM;
                pc_c       = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Reset must silence strobes even though FETCH normally requests memory.
    assign mem_req   = mem_req_c & rst_n;
    assign ir_write  = ir_c & rst_n;
    assign pc_write  = pc_c & rst_n;
    assign reg_write = rw_c & rst_n;
    assign mem_write = mw_c & rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected
// control vectors are queued with each stimulus and checked on output.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic [1:0] imm_src;
        logic [3:0] flags;
    } out_t;

    typedef struct packed {
        logic [31:0] i;
        logic [3:0]  af;
        logic        mr;
        out_t        e;
    } step_t;

    localparam logic [31:0] ADDI = 32'hE2821005;
    localparam logic [31:0] LDR  = 32'hE5910008;
    localparam logic [31:0] STR  = 32'hE5810004;
    localparam logic [31:0] CMP  = 32'hE1510002;
    localparam logic [31:0] BEQ  = 32'h0A000003;
    localparam logic [31:0] BNE  = 32'h1A000003;
    localparam logic [31:0] EOR  = 32'hE2210001;
    localparam logic [31:0] ANDS = 32'hE2110000;
    localparam logic [31:0] ORRP = 32'hE381F001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [3:0]  alu_flags = 4'h0;
    logic        mem_ready = 1'b0;
    logic        mem_req, adr_src, ir_write, pc_write;
    logic        reg_write, mem_write, alu_src_a;
    logic [1:0]  result_src, alu_src_b, alu_control, imm_src;
    logic [3:0]  flags;
    out_t        obs;
    out_t        sb[$];
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .alu_flags   (alu_flags),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .flags       (flags)
    );

    assign obs = {mem_req, adr_src, ir_write, pc_write, reg_write,
                  mem_write, result_src, alu_src_a, alu_src_b,
                  alu_control, imm_src, flags};

    function automatic out_t ex(logic mq, logic ad, logic ir, logic pc,
                                logic rw, logic mw, logic [1:0] res,
                                logic a, logic [1:0] b, logic [1:0] alu,
                                logic [1:0] imm, logic [3:0] f);
        return {mq, ad, ir, pc, rw, mw, res, a, b, alu, imm, f};
    endfunction

    function automatic out_t fetch(logic mr, logic [1:0] imm, logic [3:0] f);
        return ex(1, 0, mr, mr, 0, 0, 2'd2, 1, 2'd2, 2'd0, imm, f);
    endfunction
    function automatic out_t decode(logic [1:0] imm, logic [3:0] f);
        return ex(0, 0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, imm, f);
    endfunction
    function automatic out_t memadr(logic [3:0] f);
        return ex(0, 0, 0, 0, 0, 0, 2'd2, 0, 2'd1, 2'd0, 2'd1, f);
    endfunction
    function automatic out_t memrd(logic [3:0] f);
        return ex(1, 1, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, 2'd1, f);
    endfunction
    function automatic out_t memwb(logic pc, logic [3:0] f);
        return ex(0, 0, 0, pc, 1, 0, 2'd1, 1, 2'd2, 2'd0, 2'd1, f);
    endfunction
    function automatic out_t memwr(logic [3:0] f);
        return ex(1, 1, 0, 0, 0, 1, 2'd2, 1, 2'd2, 2'd0, 2'd1, f);
    endfunction
    function automatic out_t exec(logic i, logic [1:0] alu, logic [3:0] f);
        return ex(0, 0, 0, 0, 0, 0, 2'd2, 0, i ? 2'd1 : 2'd0, alu, 2'd0, f);
    endfunction
    function automatic out_t aluwb(logic rw, logic pc, logic [3:0] f);
        return ex(0, 0, 0, pc, rw, 0, 2'd0, 1, 2'd2, 2'd0, 2'd0, f);
    endfunction
    function automatic out_t branch(logic [3:0] f);
        return ex(0, 0, 0, 1, 0, 0, 2'd2, 0, 2'd1, 2'd0, 2'd2, f);
    endfunction
    function automatic out_t rst(logic [1:0] imm);
        return ex(0, 0, 0, 0, 0, 0, 2'd2, 1, 2'd2, 2'd0, imm, 4'h0);
    endfunction

    task automatic drive(input step_t s);
        instr     = s.i;
        alu_flags = s.af;
        mem_ready = s.mr;
        sb.push_back(s.e);
        #1;
    endtask

    task automatic test_reset;
        step_t s[$];
        out_t e;
        s.push_back('{32'h0, 4'h0, 1'b1, rst(2'd0)});
        s.push_back('{32'h0, 4'h0, 1'b1, rst(2'd0)});
        s.push_back('{32'h0, 4'h0, 1'b0, fetch(0, 2'd0, 4'h0)});
        foreach (s[k]) begin
            @(negedge clk);
            rst_n = (k >= 2);
            drive(s[k]);
            e = sb.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL reset cyc%0d got %h want %h", k, obs, e);
            end
        end
    endtask

    task automatic run(input string name, input step_t s[$]);
        out_t e;
        foreach (s[k]) begin
            @(negedge clk);
            drive(s[k]);
            e = sb.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL %s cyc%0d got %h want %h", name, k, obs, e);
            end
        end
    endtask

    task automatic test_add;
        step_t s[$];
        s.push_back('{ADDI, 4'h0, 1'b1, fetch(1, 2'd0, 4'h0)});
        s.push_back('{ADDI, 4'h0, 1'b1, decode(2'd0, 4'h0)});
        s.push_back('{ADDI, 4'h0, 1'b1, exec(1, 2'd0, 4'h0)});
        s.push_back('{ADDI, 4'h0, 1'b1, aluwb(1, 0, 4'h0)});
        run("add", s);
    endtask

    task automatic test_ldr_stall;
        step_t s[$];
        s.push_back('{LDR, 4'h0, 1'b1, fetch(1, 2'd1, 4'h0)});
        s.push_back('{LDR, 4'h0, 1'b1, decode(2'd1, 4'h0)});
        s.push_back('{LDR, 4'h0, 1'b0, memadr(4'h0)});
        s.push_back('{LDR, 4'h0, 1'b0, memrd(4'h0)});
        s.push_back('{LDR, 4'h0, 1'b0, memrd(4'h0)});
        s.push_back('{LDR, 4'h0, 1'b1, memrd(4'h0)});
        s.push_back('{LDR, 4'h0, 1'b1, memwb(0, 4'h0)});
        run("ldr", s);
    endtask

    task automatic test_str;
        step_t s[$];
        s.push_back('{STR, 4'h0, 1'b1, fetch(1, 2'd1, 4'h0)});
        s.push_back('{STR, 4'h0, 1'b1, decode(2'd1, 4'h0)});
        s.push_back('{STR, 4'h0, 1'b0, memadr(4'h0)});
        s.push_back('{STR, 4'h0, 1'b0, memwr(4'h0)});
        s.push_back('{STR, 4'h0, 1'b1, memwr(4'h0)});
        run("str", s);
    endtask

    task automatic test_cmp_beq;
        step_t s[$];
        s.push_back('{CMP, 4'h4, 1'b1, fetch(1, 2'd0, 4'h0)});
        s.push_back('{CMP, 4'h4, 1'b1, decode(2'd0, 4'h0)});
        s.push_back('{CMP, 4'h4, 1'b1, exec(0, 2'd1, 4'h0)});
        s.push_back('{CMP, 4'h4, 1'b1, aluwb(0, 0, 4'h0)});
        s.push_back('{BEQ, 4'h0, 1'b1, fetch(1, 2'd2, 4'h4)});
        s.push_back('{BEQ, 4'h0, 1'b1, decode(2'd2, 4'h4)});
        s.push_back('{BEQ, 4'h0, 1'b1, branch(4'h4)});
        run("cmp_beq", s);
    endtask

    task automatic test_skip;
        step_t s[$];
        s.push_back('{BNE, 4'h0, 1'b1, fetch(1, 2'd2, 4'h4)});
        s.push_back('{BNE, 4'h0, 1'b1, decode(2'd2, 4'h4)});
        s.push_back('{BNE, 4'h0, 1'b0, fetch(0, 2'd2, 4'h4)});
        s.push_back('{EOR, 4'h0, 1'b1, fetch(1, 2'd0, 4'h4)});
        s.push_back('{EOR, 4'h0, 1'b1, decode(2'd0, 4'h4)});
        s.push_back('{EOR, 4'h0, 1'b0, fetch(0, 2'd0, 4'h4)});
        run("skip", s);
    endtask

    task automatic test_fetch_stall;
        step_t s[$];
        s.push_back('{ADDI, 4'h0, 1'b0, fetch(0, 2'd0, 4'h4)});
        s.push_back('{ADDI, 4'h0, 1'b0, fetch(0, 2'd0, 4'h4)});
        s.push_back('{ADDI, 4'h0, 1'b0, fetch(0, 2'd0, 4'h4)});
        s.push_back('{ADDI, 4'h0, 1'b1, fetch(1, 2'd0, 4'h4)});
        s.push_back('{ADDI, 4'h0, 1'b1, decode(2'd0, 4'h4)});
        s.push_back('{ADDI, 4'h0, 1'b1, exec(1, 2'd0, 4'h4)});
        s.push_back('{ADDI, 4'h0, 1'b1, aluwb(1, 0, 4'h4)});
        run("fetch_stall", s);
    endtask

    task automatic test_logic_flags_pc;
        step_t s[$];
        s.push_back('{ANDS, 4'hB, 1'b1, fetch(1, 2'd0, 4'h4)});
        s.push_back('{ANDS, 4'hB, 1'b1, decode(2'd0, 4'h4)});
        s.push_back('{ANDS, 4'hB, 1'b1, exec(1, 2'd2, 4'h4)});
        s.push_back('{ANDS, 4'hB, 1'b1, aluwb(1, 0, 4'h4)});
        s.push_back('{ORRP, 4'hF, 1'b1, fetch(1, 2'd0, 4'h8)});
        s.push_back('{ORRP, 4'hF, 1'b1, decode(2'd0, 4'h8)});
        s.push_back('{ORRP, 4'hF, 1'b1, exec(1, 2'd3, 4'h8)});
        s.push_back('{ORRP, 4'hF, 1'b1, aluwb(1, 1, 4'h8)});
        run("logic_pc", s);
    endtask

    task automatic test_reset_midstall;
        step_t s[$];
        out_t e;
        s.push_back('{LDR, 4'h0, 1'b1, fetch(1, 2'd1, 4'h8)});
        s.push_back('{LDR, 4'h0, 1'b1, decode(2'd1, 4'h8)});
        s.push_back('{LDR, 4'h0, 1'b0, memadr(4'h8)});
        s.push_back('{LDR, 4'h0, 1'b0, memrd(4'h8)});
        run("pre_rst", s);
        #2;
        rst_n = 1'b0;
        sb.push_back(rst(2'd1));
        #1;
        e = sb.pop_front();
        tests++;
        if (obs !== e) begin
            failed++;
            $display("FAIL rst_async got %h want %h", obs, e);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2)
                rst_n = 1'b1;
            drive('{LDR, 4'h0, k != 2,
                    (k == 2) ? fetch(0, 2'd1, 4'h0) : rst(2'd1)});
            e = sb.pop_front();
            tests++;
            if (obs !== e) begin
                failed++;
                $display("FAIL rst_hold cyc%0d got %h want %h", k, obs, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_ldr_stall();
        test_str();
        test_cmp_beq();
        test_skip();
        test_fetch_stall();
        test_logic_flags_pc();
        test_reset_midstall();
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard left %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle control unit for the ARM-subset core. Decodes the instruction register's cond/op/funct/rd fields and sequences FETCH→DECODE→execute→writeback.
- Drives all datapath mux selects and write strobes.
- Generates imm_src, the 2-bit op-select consumed by the immediate extender: 00 = 8-bit data-processing, 01 = 12-bit memory, 10 = 24-bit branch.
- Holds the NZCV flags register and evaluates condition codes.

Parameters:
- PC_REG, 4'd15: register index treated as PC for writeback redirect.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction register contents
- alu_flags  in  4  NZCV from ALU, same cycle
- mem_ready  in  1  memory completes request this cycle
- mem_req  out  1  memory access active
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- reg_write  out  1  register file write
- mem_write  out  1  memory write
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_src_a  out  1  0 = reg A, 1 = PC
- alu_src_b  out  2  00 reg B, 01 extended imm, 10 constant 4
- alu_control  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- imm_src  out  2  extender op-select
- flags  out  4  current NZCV register

Behaviour:
- Reset (rst_n low, async):
  - state = FETCH; flags = 0000.
  - All strobes (mem_req, ir_write, pc_write, reg_write, mem_write) are forced 0 while rst_n is low.
  - Mux outputs take their FETCH values.
  - Reset asserted in any state (including mid-stall) aborts the instruction; no partial write occurs after rst_n falls.
- Field decode:
  - cond = instr[31:28]; op = instr[27:26]; funct = instr[25:20] (I = funct[5], cmd = funct[4:1], S/L = funct[0]); rd = instr[15:12].
- imm_src is combinational, valid in every state: op for op ∈ {00, 01, 10}; 00 for op = 11.
- ALU decode, data-processing cmd:
  - 0100 → ADD; 0010 → SUB; 0000 → AND; 1100 → ORR.
  - 1010 (CMP) → SUB with no register write.
  - Any other cmd is illegal.
- Condition evaluation (in DECODE, against the flags register): standard ARM EQ..LE; 1110 (AL) = true; 1111 = false.
- States and transitions:
  - FETCH:
    - Outputs: mem_req = 1, adr_src = 0, alu_src_a = 1, alu_src_b = 10, ADD, result_src = 10.
    - On mem_ready: ir_write = pc_write = 1 for that single cycle, then go to DECODE; otherwise hold, strobes 0.
  - DECODE:
    - Outputs: alu_src_a = 1, alu_src_b = 10, ADD (forms PC+8).
    - If !cond_ex, or op = 11, or illegal cmd → FETCH.
    - Otherwise: op 00 → EXECI if I, else EXECR; op 01 → MEMADR; op 10 → BRANCH.
  - MEMADR:
    - Outputs: alu_src_a = 0, alu_src_b = 01, ADD.
    - Next: MEMRD if L, else MEMWR.
  - MEMRD: mem_req = 1, adr_src = 1; wait for mem_ready, then MEMWB.
  - MEMWB: result_src = 01, reg_write = 1; pc_write = 1 if rd == PC_REG; next FETCH.
  - MEMWR: mem_req = mem_write = 1, adr_src = 1; held until mem_ready, then FETCH.
  - EXECR: alu_src_a = 0, alu_src_b = 00, decoded ALU op; next ALUWB.
  - EXECI: alu_src_a = 0, alu_src_b = 01, decoded ALU op; next ALUWB.
  - ALUWB:
    - result_src = 00.
    - reg_write = 1 unless CMP.
    - pc_write = 1 if rd == PC_REG and not CMP.
    - If S: N and Z are loaded from alu_flags. C and V are loaded only for ADD/SUB (the op latched in EXEC); otherwise retained.
    - Next FETCH.
  - BRANCH: alu_src_a = 0, alu_src_b = 01, ADD, result_src = 10, pc_write = 1; next FETCH.
- All strobes are single-cycle except mem_req/mem_write, which are held through stalls. No strobe is asserted outside the states listed above.

Decomposition:
- Shared package cpu_pkg:
  - state enum;
  - ALU_ADD/SUB/AND/ORR codes;
  - IMM_DP/IMM_MEM/IMM_BR codes (00/01/10);
  - RES_ALUOUT/RES_DATA/RES_ALU codes;
  - SRCB_REG/IMM/FOUR codes;
  - condition-code constants.
- Sub-module cond_unit: combinational cond_ex from cond + flags, plus the flag-register update logic.

Test Plan:
- Assert rst_n low during MEMRD stall → state FETCH immediately; flags = 0000; all strobes 0 until rst_n high.
- instr 0xE2821005 (ADD R1,R2,#5), mem_ready = 1 → FETCH, DECODE, EXECI, ALUWB in 4 cycles; imm_src = 00; alu_control = 00; reg_write only in cycle 4.
- instr 0xE5910008 (LDR R0,[R1,#8]), mem_ready low 2 cycles in MEMRD → MEMRD lasts 3 cycles with mem_req = 1, adr_src = 1; imm_src = 01; one reg_write in MEMWB.
- instr 0xE1510002 (CMP R1,R2), alu_flags = 0100 → no reg_write, flags = 0100. Then 0x0A000003 (BEQ) → BRANCH with pc_write = 1, imm_src = 10.
- flags Z = 1, instr 0x1A000003 (BNE) → DECODE returns to FETCH; no pc_write after FETCH.
- mem_ready low 3 cycles in FETCH → ir_write/pc_write stay 0; each asserts exactly one cycle when mem_ready rises.
